// File: rtl/sevenseg_scan.sv
// sevenseg_scan: N-digit multiplexed common-anode 7-segment driver with frame-aligned double buffering, blink and 16-level PWM
module sevenseg_scan #(
  parameter int NDIG       = 4,
  parameter int SCAN_LOG2  = 15,
  parameter int BLINK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [8*NDIG-1:0] chars,
  input  logic [NDIG-1:0]   dp_mask,
  input  logic [NDIG-1:0]   blink_mask,
  input  logic              load,
  input  logic [3:0]        bright,
  input  logic              enable,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);
  localparam logic [SCAN_LOG2-1:0]  SC_ONE = 1;
  localparam logic [BLINK_LOG2-1:0] FC_ONE = 1;
  localparam logic [2:0]            D_LAST = 3'(NDIG - 1);
  logic [SCAN_LOG2-1:0]  r_sc;
  logic [2:0]            r_d;
  logic [BLINK_LOG2-1:0] r_fc;
  logic                  r_blink_on;
  logic [8*NDIG-1:0]     r_act_chars, r_pend_chars;
  logic [NDIG-1:0]       r_act_dp, r_pend_dp, r_act_bl, r_pend_bl;
  logic                  r_pend;
  logic [7:0]            r_seg;
  logic [NDIG-1:0]       r_an;
  logic                  r_frame_done;
  logic                  w_slot_end, w_boundary, w_dp, w_bl, w_lit;
  logic [7:0]            w_char;
  function automatic logic [7:0] glyph(input logic [7:0] c);
    logic [7:0] g;
    g = 8'hFE;
    case (c)
      8'h20: g = 8'hFF; 8'h2D: g = 8'hBF; 8'h5F: g = 8'hF7;
      8'h30: g = 8'hC0; 8'h31: g = 8'hF9; 8'h32: g = 8'hA4; 8'h33: g = 8'hB0;
      8'h34: g = 8'h99; 8'h35: g = 8'h92; 8'h36: g = 8'h82; 8'h37: g = 8'hF8;
      8'h38: g = 8'h80; 8'h39: g = 8'h90;
      8'h41: g = 8'h88; 8'h43: g = 8'hC6; 8'h45: g = 8'h86; 8'h46: g = 8'h8E;
      8'h47: g = 8'h82; 8'h48: g = 8'h89; 8'h4B: g = 8'h8F; 8'h4C: g = 8'hC7;
      8'h50: g = 8'h8C; 8'h53: g = 8'h92;
      8'h62: g = 8'h83; 8'h64: g = 8'hA1; 8'h6F: g = 8'hA3;
      default: g = 8'hFE;
    endcase
    return g;
  endfunction
  assign w_slot_end = r_sc == '1;
  assign w_boundary = w_slot_end && r_d == D_LAST;
  assign w_char     = 8'(r_act_chars >> {r_d, 3'b000});
  assign w_dp       = 1'(r_act_dp >> r_d);
  assign w_bl       = 1'(r_act_bl >> r_d);
  // PWM phase is the top nibble of the slot counter
  assign w_lit      = enable && (!w_bl || r_blink_on) && (r_sc[SCAN_LOG2-1 -: 4] <= bright);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sc         <= '0;
      r_d          <= '0;
      r_fc         <= '0;
      r_blink_on   <= 1'b1;
      r_act_chars  <= {NDIG{8'h20}};
      r_pend_chars <= {NDIG{8'h20}};
      r_act_dp     <= '0;
      r_pend_dp    <= '0;
      r_act_bl     <= '0;
      r_pend_bl    <= '0;
      r_pend       <= 1'b0;
      r_seg        <= 8'hFF;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_sc         <= r_sc + SC_ONE;
      r_d          <= w_slot_end ? (r_d == D_LAST ? 3'd0 : r_d + 3'd1) : r_d;
      r_seg        <= glyph(w_char) & ~{w_dp, 7'b0};
      r_an         <= ~(NDIG'(w_lit) << r_d);
      r_frame_done <= w_boundary;
      if (w_boundary) begin
        r_fc       <= r_fc + FC_ONE;
        r_blink_on <= r_fc == '1 ? !r_blink_on : r_blink_on;
        r_pend     <= 1'b0;
        if (load || r_pend) begin
          r_act_chars <= load ? chars : r_pend_chars;
          r_act_dp    <= load ? dp_mask : r_pend_dp;
          r_act_bl    <= load ? blink_mask : r_pend_bl;
        end
      end else if (load) begin
        r_pend_chars <= chars;
        r_pend_dp    <= dp_mask;
        r_pend_bl    <= blink_mask;
        r_pend       <= 1'b1;
      end
    end
  end
  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: random + directed checks of sevenseg_scan against a time-indexed behavioural model
module tb_sevenseg_scan;
  logic        clk = 0, rstn = 0;
  logic [31:0] chars = 32'h20202020;
  logic [3:0]  dp_mask = 0, blink_mask = 0, bright = 4'hF;
  logic        load = 0, enable = 1;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sevenseg_scan #(.NDIG(4), .SCAN_LOG2(4), .BLINK_LOG2(1)) dut (
    .clk(clk), .rstn(rstn), .chars(chars), .dp_mask(dp_mask), .blink_mask(blink_mask),
    .load(load), .bright(bright), .enable(enable), .seg(seg), .an(an), .frame_done(frame_done)
  );
  logic [7:0] gl [256];
  initial begin
    for (int i = 0; i < 256; i++) gl[i] = 8'hFE;
    gl[8'h20] = 8'hFF; gl[8'h2D] = 8'hBF; gl[8'h5F] = 8'hF7;
    gl[8'h30] = 8'hC0; gl[8'h31] = 8'hF9; gl[8'h32] = 8'hA4; gl[8'h33] = 8'hB0; gl[8'h34] = 8'h99;
    gl[8'h35] = 8'h92; gl[8'h36] = 8'h82; gl[8'h37] = 8'hF8; gl[8'h38] = 8'h80; gl[8'h39] = 8'h90;
    gl[8'h41] = 8'h88; gl[8'h43] = 8'hC6; gl[8'h45] = 8'h86; gl[8'h46] = 8'h8E; gl[8'h47] = 8'h82;
    gl[8'h48] = 8'h89; gl[8'h4B] = 8'h8F; gl[8'h4C] = 8'hC7; gl[8'h50] = 8'h8C; gl[8'h53] = 8'h92;
    gl[8'h62] = 8'h83; gl[8'h64] = 8'hA1; gl[8'h6F] = 8'hA3;
  end
  // model: t = clocks since reset release; digit = (t/16)%4, frame = t/64, blink on when (frame/2) even
  int         t;
  logic [7:0] m_act [4], m_pend [4];
  logic [3:0] m_adp, m_pdp, m_abl, m_pbl;
  bit         m_pf;
  logic [7:0] exp_seg = 8'hFF;
  logic [3:0] exp_an = 4'hF;
  logic       exp_fd = 0;
  function automatic bit vis(int tt);
    return enable && (!m_abl[(tt/16)%4] || ((tt/64)/2)%2 == 0) && (tt%16) <= int'(bright);
  endfunction
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t <= 0;
      for (int i = 0; i < 4; i++) begin m_act[i] <= 8'h20; m_pend[i] <= 8'h20; end
      m_adp <= 0; m_pdp <= 0; m_abl <= 0; m_pbl <= 0; m_pf <= 0;
      exp_seg <= 8'hFF; exp_an <= 4'hF; exp_fd <= 0;
    end else begin
      exp_seg <= gl[m_act[(t/16)%4]] & (m_adp[(t/16)%4] ? 8'h7F : 8'hFF);
      exp_an  <= vis(t) ? ~(4'b0001 << ((t/16)%4)) : 4'hF;
      exp_fd  <= (t%64 == 63);
      if (t%64 == 63) begin
        m_pf <= 0;
        if (load) begin
          for (int i = 0; i < 4; i++) m_act[i] <= chars[8*i +: 8];
          m_adp <= dp_mask; m_abl <= blink_mask;
        end else if (m_pf) begin
          m_act <= m_pend; m_adp <= m_pdp; m_abl <= m_pbl;
        end
      end else if (load) begin
        for (int i = 0; i < 4; i++) m_pend[i] <= chars[8*i +: 8];
        m_pdp <= dp_mask; m_pbl <= blink_mask; m_pf <= 1;
      end
      t <= t + 1;
    end
  end
  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, got, want, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("model_seg", seg, exp_seg);
    chk("model_an", {4'h0, an}, {4'h0, exp_an});
    chk("model_fd", {7'h0, frame_done}, {7'h0, exp_fd});
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  int cnt;
  logic [7:0] pool [8] = '{8'h31, 8'h32, 8'h41, 8'h2D, 8'h6F, 8'h38, 8'h20, 8'h5F};
  initial begin
    step(3);
    rstn = 1;
    step(1);
    chk("rst_an_d0", {4'h0, an}, 8'h0E);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_fd", {7'h0, frame_done}, 8'h00);
    step(16); chk("scan_an_d1", {4'h0, an}, 8'h0D);
    step(16); chk("scan_an_d2", {4'h0, an}, 8'h0B);
    step(16); chk("scan_an_d3", {4'h0, an}, 8'h07);
    step(15); chk("fd_pulse", {7'h0, frame_done}, 8'h01);
    step(1);  chk("fd_clear", {7'h0, frame_done}, 8'h00);
    chars = {8'h42, 8'h41, 8'h32, 8'h31}; dp_mask = 4'b0010; load = 1;
    step(1); load = 0;
    chk("no_tear_early", seg, 8'hFF);
    step(62); chk("no_tear_late", seg, 8'hFF);
    step(1);  chk("glyph_1", seg, 8'hF9);
    step(16); chk("glyph_2dp", seg, 8'h24);
    step(16); chk("glyph_A", seg, 8'h88);
    step(16); chk("glyph_B_unknown", seg, 8'hFE);
    chars = 32'h30303030; dp_mask = 0; load = 1;
    step(1); chars = 32'h39393939;
    step(1); load = 0;
    step(13); chk("old_until_boundary", seg, 8'hFE);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin step(1); cnt += (seg == 8'h90) ? 1 : 0; end
    chk("second_load_wins", 8'(cnt), 8'd64);
    step(63);
    chars = 32'h38383838; load = 1;
    step(1); load = 0;
    chk("bnd_load_d3_old", seg, 8'h90);
    step(1); chk("bnd_load_d0_new", seg, 8'h80);
    step(63);
    bright = 7; cnt = 0;
    for (int i = 0; i < 64; i++) begin step(1); cnt += (an != 4'hF) ? 1 : 0; end
    chk("bright7", 8'(cnt), 8'd32);
    bright = 0; cnt = 0;
    for (int i = 0; i < 64; i++) begin step(1); cnt += (an != 4'hF) ? 1 : 0; end
    chk("bright0", 8'(cnt), 8'd4);
    bright = 15; cnt = 0;
    for (int i = 0; i < 64; i++) begin step(1); cnt += (an != 4'hF) ? 1 : 0; end
    chk("bright15", 8'(cnt), 8'd64);
    enable = 0;
    step(1); chk("enable_off", {4'h0, an}, 8'h0F);
    enable = 1;
    step(7);
    #2 rstn = 0;
    #1 chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_an", {4'h0, an}, 8'h0F);
    step(2);
    rstn = 1; chars = 32'h38383838; blink_mask = 4'b0001; load = 1;
    step(1); load = 0; blink_mask = 0;
    step(64);  chk("blink_f1_lit", {4'h0, an}, 8'h0E);
    step(64);  chk("blink_f2_dark", {4'h0, an}, 8'h0F);
    chk("blink_f2_seg", seg, 8'h80);
    step(16);  chk("blink_f2_d1_lit", {4'h0, an}, 8'h0D);
    step(48);  chk("blink_f3_dark", {4'h0, an}, 8'h0F);
    step(64);  chk("blink_f4_lit", {4'h0, an}, 8'h0E);
    for (int i = 0; i < 4000; i++) begin
      load = ($urandom % 12) == 0;
      if (load) begin
        for (int k = 0; k < 4; k++)
          chars[8*k +: 8] = ($urandom % 4 == 0) ? 8'($urandom) : pool[$urandom % 8];
        dp_mask = 4'($urandom); blink_mask = 4'($urandom);
      end
      if ($urandom % 40 == 0) bright = 4'($urandom);
      if ($urandom % 30 == 0) enable = ($urandom % 4) != 0;
      if (i == 2500) rstn = 0;
      if (i == 2503) rstn = 1;
      step(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
